// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants shared by the scan stage and its delay line.
package vga_timing_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // 10-bit forms so counter compares stay width-matched
  localparam logic [9:0] H_VIS_C      = 10'(H_VIS);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_VIS_C      = 10'(V_VIS);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } scan_ctl_t;

  localparam scan_ctl_t CTL_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_delay.sv
// Enabled shift register used to hold raster control bits back by the color lookup latency.
module vga_delay #(
  parameter int                WIDTH     = 3,
  parameter int                DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan.sv
// VGA 640x480 raster scan, lookup-latency alignment and registered RGB/sync pins.
// Define VGA_CLKDIV_EN to run from a 4x clock with an internal pixel-enable divider.
module vga_scan
  import vga_timing_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] icolor,
  output logic [9:0]  posX,
  output logic [8:0]  posY,
  output logic        pix_en,
  output logic        vblank_start,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  logic [9:0] hcnt;
  logic [9:0] vcnt;
  scan_ctl_t  ctl_raw;
  scan_ctl_t  ctl_q;
  scan_ctl_t  ctl_dly;
  logic       unused_color_hi;

  assign unused_color_hi = ^icolor[15:12];

`ifdef VGA_CLKDIV_EN
  logic [1:0] div;

  always_ff @(posedge clk) begin
    if (rst) div <= 2'd0;
    else     div <= div + 2'd1;
  end

  assign pix_en = (div == 2'd3);
`else
  assign pix_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  always_comb begin
    ctl_raw.vis = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    ctl_raw.hs  = !((hcnt >= H_SYNC_START) && (hcnt <= H_SYNC_END));
    ctl_raw.vs  = !((vcnt >= V_SYNC_START) && (vcnt <= V_SYNC_END));
  end

  // Control bits are registered with the coordinates so the delay counts from posX/posY
  always_ff @(posedge clk) begin
    if (rst) begin
      posX         <= '0;
      posY         <= '0;
      vblank_start <= 1'b0;
      ctl_q        <= CTL_IDLE;
    end else if (pix_en) begin
      posX         <= ctl_raw.vis ? hcnt : 10'd0;
      posY         <= ctl_raw.vis ? vcnt[8:0] : 9'd0;
      vblank_start <= (hcnt == 10'd0) && (vcnt == V_VIS_C);
      ctl_q        <= ctl_raw;
    end
  end

  vga_delay #(
    .WIDTH     (3),
    .DEPTH     (PIPE_LAT),
    .RESET_VAL (CTL_IDLE)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (pix_en),
    .d   (ctl_q),
    .q   (ctl_dly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hs <= 1'b1;
      vs <= 1'b1;
      r  <= '0;
      g  <= '0;
      b  <= '0;
    end else if (pix_en) begin
      hs <= ctl_dly.hs;
      vs <= ctl_dly.vs;
      r  <= ctl_dly.vis ? icolor[R_MSB:R_LSB] : 4'd0;
      g  <= ctl_dly.vis ? icolor[G_MSB:G_LSB] : 4'd0;
      b  <= ctl_dly.vis ? icolor[B_MSB:B_LSB] : 4'd0;
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Self-checking bench for vga_scan: raster model with a queue of issued pixels and an emulated lookup stage.
module tb_vga_scan;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] icolor;
  logic [9:0]  posX;
  logic [8:0]  posY;
  logic        pix_en;
  logic        vblank_start;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  int checks = 0;
  int errors = 0;

  vga_scan #(.PIPE_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .icolor       (icolor),
    .posX         (posX),
    .posY         (posY),
    .pix_en       (pix_en),
    .vblank_start (vblank_start),
    .hs           (hs),
    .vs           (vs),
    .r            (r),
    .g            (g),
    .b            (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vis;
    bit hs;
    bit vs;
    int mx;
    int my;
    int dx;
    int dy;
  } rec_t;

  rec_t        hist[$];
  int          mx;
  int          my;
  logic [11:0] salt;

  bit measure   = 0;
  int hsLowCnt  = 0;
  int vsLowCnt  = 0;
  int vblankCnt = 0;
  int sinceRel  = 0;
  int fallAt    = -1;
  bit prevHs    = 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] colorOf(input int x, input int y);
    logic [3:0] yl;
    logic [7:0] xl;
    yl = y[3:0];
    xl = x[7:0];
    return {yl, xl} ^ salt;
  endfunction

  task automatic modelReset();
    rec_t blank;
    blank.vis = 0; blank.hs = 1; blank.vs = 1;
    blank.mx = 0; blank.my = 0; blank.dx = 0; blank.dy = 0;
    mx = 0;
    my = 0;
    hist.delete();
    for (int i = 0; i <= LAT; i++) hist.push_back(blank);
    sinceRel = 0;
    fallAt   = -1;
    prevHs   = 1;
  endtask

  // One pixel clock: drive reset, sample after the edge, check against the model, drive the lookup result
  task automatic applyStimulus(input bit doReset);
    rec_t cur;
    rec_t outRec;
    rec_t lookRec;
    int   expX;
    int   expY;
    int   expRgb;
    rst = doReset;
    @(posedge clk);
    #1;
    if (doReset) begin
      modelReset();
      checkOutput("rst_posX", posX, 0);
      checkOutput("rst_posY", posY, 0);
      checkOutput("rst_hs", hs, 1);
      checkOutput("rst_vs", vs, 1);
      checkOutput("rst_rgb", {r, g, b}, 0);
      checkOutput("rst_vblank", vblank_start, 0);
      icolor = 16'($urandom);
    end else begin
      cur.vis = (mx < 640) && (my < 480);
      cur.hs  = !((mx >= 656) && (mx <= 751));
      cur.vs  = !((my >= 490) && (my <= 491));
      cur.mx  = mx;
      cur.my  = my;
      cur.dx  = int'(posX);
      cur.dy  = int'(posY);
      expX = cur.vis ? mx : 0;
      expY = cur.vis ? my : 0;
      checkOutput("posX", posX, expX);
      checkOutput("posY", posY, expY);
      checkOutput("vblank_start", vblank_start, (mx == 0 && my == 480) ? 1 : 0);
      checkOutput("pix_en", pix_en, 1);
      hist.push_back(cur);

      outRec = hist[hist.size() - 1 - (LAT + 1)];
      expRgb = outRec.vis ? int'(colorOf(outRec.mx, outRec.my)) : 0;
      checkOutput("hs", hs, outRec.hs);
      checkOutput("vs", vs, outRec.vs);
      checkOutput("rgb", {r, g, b}, expRgb);

      lookRec = hist[hist.size() - 1 - LAT];
      if (lookRec.vis) icolor = {4'($urandom), colorOf(lookRec.dx, lookRec.dy)};
      else             icolor = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
      while (hist.size() > LAT + 2) void'(hist.pop_front());

      if (!hs && prevHs && fallAt < 0) fallAt = sinceRel;
      prevHs = hs;
      sinceRel++;
      if (measure) begin
        hsLowCnt  += (hs == 1'b0) ? 1 : 0;
        vsLowCnt  += (vs == 1'b0) ? 1 : 0;
        vblankCnt += (vblank_start == 1'b1) ? 1 : 0;
      end

      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic jumpTo(input int h, input int v);
    force dut.hcnt = 10'(h);
    force dut.vcnt = 10'(v);
    #1;
    release dut.hcnt;
    release dut.vcnt;
    mx = h;
    my = v;
  endtask

  task automatic clearMeasure();
    hsLowCnt  = 0;
    vsLowCnt  = 0;
    vblankCnt = 0;
  endtask

  initial begin
    int guard;
    salt   = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    rst    = 1'b1;
    icolor = 16'h0000;
    $display("[TB] salt=%0h PIPE_LAT=%0d", salt, LAT);

    repeat (3) applyStimulus(1'b1);

    repeat (100 + $urandom_range(0, 100)) applyStimulus(1'b0);
    clearMeasure();
    measure = 1;
    repeat (800) applyStimulus(1'b0);
    measure = 0;
    checkOutput("hs_low_per_line", hsLowCnt, 96);
    checkOutput("hs_first_fall", fallAt, 656 + LAT + 1);

    guard = 0;
    while (mx != 300 && guard < 2000) begin
      applyStimulus(1'b0);
      guard++;
    end
    checkOutput("reach_hcnt_300", mx, 300);
    repeat (3) applyStimulus(1'b1);
    repeat (1700 + $urandom_range(0, 200)) applyStimulus(1'b0);

    jumpTo(0, 476);
    clearMeasure();
    measure = 1;
    repeat (16000) applyStimulus(1'b0);
    measure = 0;
    checkOutput("vs_low_pixels", vsLowCnt, 1600);
    checkOutput("vblank_pulses", vblankCnt, 1);

    jumpTo(780 - $urandom_range(0, 20), 524);
    repeat (900) applyStimulus(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
